// File: rtl/btn_cond_pkg.sv
// Shared constants for the push-button conditioner: edge-mode selectors and
// the per-channel auto-repeat state encoding.
package btn_cond_pkg;

  // Edge selection for the combined pulse output
  localparam logic [1:0] EDGE_RISE = 2'd0;
  localparam logic [1:0] EDGE_FALL = 2'd1;
  localparam logic [1:0] EDGE_BOTH = 2'd2;

  // Auto-repeat FSM states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } rep_state_e;

endpackage

// File: rtl/btn_channel.sv
// One button channel: polarity fix, synchroniser, debounce counter, registered
// edge pulses and optional hold-to-repeat FSM.
module btn_channel
  import btn_cond_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned ACTIVE_LOW      = 1,
  parameter logic [1:0]  EDGE_MODE       = EDGE_RISE,
  parameter int unsigned REPEAT_EN       = 0,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic level,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic pulse
);

  localparam int unsigned CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RW   = $clog2(RMAX + 1);

  localparam logic [CW-1:0] DB_LAST    = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DELAY_LOAD = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PER_LOAD   = RW'(REPEAT_PERIOD - 1);

  localparam bit USE_RISE = (EDGE_MODE == EDGE_RISE) || (EDGE_MODE == EDGE_BOTH);
  localparam bit USE_FALL = (EDGE_MODE == EDGE_FALL) || (EDGE_MODE == EDGE_BOTH);

  logic                   in_n;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   accept;
  logic                   rise_d, fall_d;
  logic                   rise_q, fall_q;
  rep_state_e             state_q, state_d;
  logic [RW-1:0]          rcnt_q, rcnt_d;
  logic                   rep_q, rep_d;

  // Normalise to pressed-high before synchronising
  assign in_n = (ACTIVE_LOW != 0) ? ~btn_in : btn_in;
  assign sync = sync_q[SYNC_STAGES-1];

  // Synchroniser chain; resets to the released value so reset release is edge-free
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in_n};
    end
  end

  // Debounce: a new level must be seen DEBOUNCE_CYCLES consecutive cycles
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    accept  = 1'b0;
    if (sync == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == DB_LAST) begin
      accept  = 1'b1;
      level_d = sync;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign rise_d = accept & sync;
  assign fall_d = accept & ~sync;

  // Debounced level and edge pulses, updated on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // Repeat FSM next state; the load happens on the edge that accepts the press
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    rep_d   = 1'b0;
    if (REPEAT_EN != 0) begin
      unique case (state_q)
        ST_IDLE: begin
          if (rise_d) begin
            rcnt_d  = DELAY_LOAD;
            state_d = ST_DELAY;
          end
        end
        ST_DELAY, ST_REPEAT: begin
          if (!level_q) begin
            state_d = ST_IDLE;
          end else if (rcnt_q == '0) begin
            rep_d   = 1'b1;
            rcnt_d  = PER_LOAD;
            state_d = ST_REPEAT;
          end else begin
            rcnt_d = rcnt_q - 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Repeat FSM state, countdown and registered repeat pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rcnt_q  <= '0;
      rep_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      rep_q   <= rep_d;
    end
  end

  assign level      = level_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  // OR of registered terms: a coincident edge and repeat give a single pulse
  assign pulse      = (USE_RISE & rise_q) | (USE_FALL & fall_q) | rep_q;

endmodule

// File: rtl/btn_conditioner.sv
// Multi-channel push-button front end: N_CH independent btn_channel instances.
module btn_conditioner
  import btn_cond_pkg::*;
#(
  parameter int unsigned N_CH            = 4,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned ACTIVE_LOW      = 1,
  parameter logic [1:0]  EDGE_MODE       = EDGE_RISE,
  parameter int unsigned REPEAT_EN       = 0,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] rise_pulse,
  output logic [N_CH-1:0] fall_pulse,
  output logic [N_CH-1:0] pulse
);

  // Parameter sanity, caught at elaboration
  if (N_CH < 1 || N_CH > 32) begin : g_chk_nch
    $error("btn_conditioner: N_CH must be in 1..32");
  end
  if (SYNC_STAGES < 2) begin : g_chk_sync
    $error("btn_conditioner: SYNC_STAGES must be >= 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_chk_db
    $error("btn_conditioner: DEBOUNCE_CYCLES must be >= 1");
  end
  if (REPEAT_DELAY < 2) begin : g_chk_rdly
    $error("btn_conditioner: REPEAT_DELAY must be >= 2");
  end
  if (REPEAT_PERIOD < 1) begin : g_chk_rper
    $error("btn_conditioner: REPEAT_PERIOD must be >= 1");
  end

  for (genvar i = 0; i < int'(N_CH); i++) begin : g_ch
    btn_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .ACTIVE_LOW     (ACTIVE_LOW),
      .EDGE_MODE      (EDGE_MODE),
      .REPEAT_EN      (REPEAT_EN),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .btn_in    (btn_in[i]),
      .level     (level[i]),
      .rise_pulse(rise_pulse[i]),
      .fall_pulse(fall_pulse[i]),
      .pulse     (pulse[i])
    );
  end

endmodule
